andor_pipe: RTL and testbench

- Parametrised, clocked successor to the two-output AND/OR gate block.
- Processes WIDTH-bit operand vectors A, B and C. Output X = opx(A,B) and output Y = opy(B,C), each with a per-transaction selectable bitwise function.
- The fixed propagation delay becomes a LATENCY-stage register pipeline with valid/ready flow control at both ends.
- Sits between streaming producers and consumers as a generic bitwise combine stage.

---
 rtl/andor_pipe_pkg.sv | 29 ++
 rtl/andor_pipe_if.sv | 26 ++
 rtl/andor_pipe_stage.sv | 37 +++
 rtl/andor_pipe.sv | 81 ++++++++
 tb/tb_andor_pipe.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/andor_pipe_pkg.sv
// Shared types and helpers for the andor_pipe bitwise combine stage.
package andor_pkg;

  localparam int MAX_LATENCY = 8;
  localparam int MAX_W       = 64;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // Operands are zero-extended to MAX_W; callers truncate the result back.
  function automatic logic [MAX_W-1:0] apply_op(op_e op, logic [MAX_W-1:0] a,
                                                logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = a & b;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/andor_pipe_if.sv
// Streaming operand/result bus for andor_pipe: producer side in_*, consumer side out_*.
interface andor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [1:0]       in_opx;
  logic [1:0]       in_opy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;

  modport master (
    output in_valid, in_a, in_b, in_c, in_opx, in_opy, out_ready,
    input  in_ready, out_valid, out_x, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_opx, in_opy, out_ready,
    output in_ready, out_valid, out_x, out_y
  );
endinterface

// File: rtl/andor_pipe_stage.sv
// One valid/ready register slice; accepts whenever empty or draining this cycle.
module andor_pipe_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_data,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_data
);

  logic         vld_r;
  logic [W-1:0] data_r;

  assign up_rdy  = !vld_r || dn_rdy;
  assign dn_vld  = vld_r;
  assign dn_data = data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= 1'b0;
    end else if (up_rdy) begin
      vld_r <= up_vld;
    end
  end

  // Payload is unreset; only loaded on an actual transfer so it holds while stalled.
  always_ff @(posedge clk) begin
    if (up_rdy && up_vld) begin
      data_r <= up_data;
    end
  end

endmodule

// File: rtl/andor_pipe.sv
// Pipelined X=opx(A,B), Y=opy(B,C) with valid/ready at both ends.
// Optional ANDOR_PIPE_CNT_EN adds xfer_cnt (output transfer counter) and busy.
module andor_pipe
  import andor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  andor_pipe_if.slave  bus
`ifdef ANDOR_PIPE_CNT_EN
  ,
  output logic [15:0]  xfer_cnt,
  output logic         busy
`endif
);

  localparam int DW = 2 * WIDTH;

  generate
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("andor_pipe: LATENCY must be in 1..%0d", MAX_LATENCY);
    end
    if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
      $error("andor_pipe: WIDTH must be in 1..%0d", MAX_W);
    end
  endgenerate

  // Input stage: functions are evaluated here, later stages carry results only.
  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;

  assign x_p0 = WIDTH'(apply_op(op_e'(bus.in_opx), MAX_W'(bus.in_a), MAX_W'(bus.in_b)));
  assign y_p0 = WIDTH'(apply_op(op_e'(bus.in_opy), MAX_W'(bus.in_b), MAX_W'(bus.in_c)));

  logic          vld  [LATENCY+1];
  logic          rdy  [LATENCY+1];
  logic [DW-1:0] data [LATENCY+1];

  assign vld[0]       = bus.in_valid;
  assign data[0]      = {x_p0, y_p0};
  assign bus.in_ready = rdy[0];
  assign rdy[LATENCY] = bus.out_ready;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    andor_pipe_stage #(.W(DW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_vld  (vld[i]),
      .up_rdy  (rdy[i]),
      .up_data (data[i]),
      .dn_vld  (vld[i+1]),
      .dn_rdy  (rdy[i+1]),
      .dn_data (data[i+1])
    );
  end

  // Last stage is the output register; data reads as zero whenever nothing is presented.
  assign bus.out_valid = vld[LATENCY];
  assign bus.out_x     = vld[LATENCY] ? data[LATENCY][DW-1:WIDTH] : '0;
  assign bus.out_y     = vld[LATENCY] ? data[LATENCY][WIDTH-1:0]  : '0;

`ifdef ANDOR_PIPE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 16'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      busy = busy | vld[k];
    end
  end
`endif

endmodule

// File: tb/tb_andor_pipe.sv
// Self-checking bench for andor_pipe: directed scenarios plus a randomized queue-model run.
module tb_andor_pipe;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  andor_pipe_if #(.WIDTH(8)) b2 ();
  andor_pipe_if #(.WIDTH(8)) b4 ();

`ifdef ANDOR_PIPE_CNT_EN
  logic [15:0] cnt2, cnt4;
  logic        busy2, busy4;
`endif

  andor_pipe #(.WIDTH(8), .LATENCY(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
`ifdef ANDOR_PIPE_CNT_EN
    ,
    .xfer_cnt (cnt2),
    .busy     (busy2)
`endif
  );

  andor_pipe #(.WIDTH(8), .LATENCY(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
`ifdef ANDOR_PIPE_CNT_EN
    ,
    .xfer_cnt (cnt4),
    .busy     (busy4)
`endif
  );

  function automatic logic [7:0] ref_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic idle_all();
    b2.in_valid = 1'b0; b2.in_a = '0; b2.in_b = '0; b2.in_c = '0;
    b2.in_opx = '0; b2.in_opy = '0; b2.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_c = '0;
    b4.in_opx = '0; b4.in_opy = '0; b4.out_ready = 1'b1;
  endtask

  task automatic rand_in2();
    b2.in_a   = 8'($urandom);
    b2.in_b   = 8'($urandom);
    b2.in_c   = 8'($urandom);
    b2.in_opx = 2'($urandom_range(0, 3));
    b2.in_opy = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", b2.out_valid); end
    total++; if (b2.out_x !== 8'h00) begin bad++; $display("FAIL reset_out_x: got %h want 00", b2.out_x); end
    total++; if (b2.out_y !== 8'h00) begin bad++; $display("FAIL reset_out_y: got %h want 00", b2.out_y); end
    total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_l4: got %b want 0", b4.out_valid); end
`ifdef ANDOR_PIPE_CNT_EN
    total++; if (cnt2 !== 16'd0) begin bad++; $display("FAIL reset_xfer_cnt: got %0d want 0", cnt2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy2); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", b2.in_ready); end
    total++; if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_l4: got %b want 1", b4.in_ready); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    b2.in_valid = 1'b1; b2.in_a = 8'hF0; b2.in_b = 8'h3C; b2.in_c = 8'h0F;
    b2.in_opx = 2'd0; b2.in_opy = 2'd1; b2.out_ready = 1'b1;
    @(negedge clk);
    total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", b2.in_ready); end
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    @(negedge clk);
    total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", b2.out_valid); end
    @(posedge clk);
    @(negedge clk);
    total++; if (b2.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", b2.out_valid); end
    total++; if (b2.out_x !== 8'h30) begin bad++; $display("FAIL single_x: got %h want 30", b2.out_x); end
    total++; if (b2.out_y !== 8'h3F) begin bad++; $display("FAIL single_y: got %h want 3f", b2.out_y); end
    @(posedge clk);
    @(negedge clk);
    total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL single_one_pulse: got %b want 0", b2.out_valid); end
  endtask

  task automatic test_all_ops();
    logic [7:0] ex [4];
    logic [7:0] ey [4];
    ex = '{8'h88, 8'hEE, 8'h66, 8'h77};
    ey = '{8'h44, 8'hDD, 8'h99, 8'hBB};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      b2.in_valid = 1'b1; b2.in_a = 8'hAA; b2.in_b = 8'hCC; b2.in_c = 8'h55;
      b2.in_opx = 2'(k); b2.in_opy = 2'(k);
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (b2.out_valid !== 1'b1) begin bad++; $display("FAIL ops_valid[%0d]: got %b want 1", k, b2.out_valid); end
      total++; if (b2.out_x !== ex[k]) begin bad++; $display("FAIL ops_x[%0d]: got %h want %h", k, b2.out_x, ex[k]); end
      total++; if (b2.out_y !== ey[k]) begin bad++; $display("FAIL ops_y[%0d]: got %h want %h", k, b2.out_y, ey[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q [$];
    logic [15:0] e;
    logic [7:0]  hx, hy;
    logic        held;
    int          sent, got;
    q.delete(); sent = 0; got = 0; held = 1'b0; hx = '0; hy = '0;
    @(posedge clk); #1;
    b2.out_ready = 1'b0; b2.in_valid = 1'b1; rand_in2();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      total++; if (b2.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, b2.in_ready, (q.size() < 2)); end
      if (held) begin
        total++; if (b2.out_valid !== 1'b1 || b2.out_x !== hx || b2.out_y !== hy) begin
          bad++; $display("FAIL bp_stable[%0d]: got %b/%h/%h want 1/%h/%h", cyc, b2.out_valid, b2.out_x, b2.out_y, hx, hy);
        end
      end else if (b2.out_valid === 1'b1) begin
        held = 1'b1; hx = b2.out_x; hy = b2.out_y;
      end
      if (b2.in_valid && b2.in_ready) begin
        q.push_back({ref_op(b2.in_opx, b2.in_a, b2.in_b), ref_op(b2.in_opy, b2.in_b, b2.in_c)});
        sent++;
      end
      @(posedge clk); #1;
      if (b2.in_valid && sent > 0 && q.size() == sent && sent < 5) rand_in2();
    end
    total++; if (sent !== 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", sent); end
    b2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      @(negedge clk);
      if (b2.out_valid && b2.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        total++; if ({b2.out_x, b2.out_y} !== e) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", got, {b2.out_x, b2.out_y}, e); end
        got++;
      end
      if (b2.in_valid && b2.in_ready) begin
        q.push_back({ref_op(b2.in_opx, b2.in_a, b2.in_b), ref_op(b2.in_opy, b2.in_b, b2.in_c)});
        sent++;
      end
      @(posedge clk); #1;
      if (sent >= 5) b2.in_valid = 1'b0;
      else rand_in2();
    end
    total++; if (got !== 5) begin bad++; $display("FAIL bp_all_out: got %0d want 5", got); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", q.size()); end
  endtask

  task automatic test_bubble();
    int n;
    n = 0;
    @(posedge clk); #1;
    b4.out_ready = 1'b0; b4.in_valid = 1'b1;
    b4.in_a = 8'h12; b4.in_b = 8'h34; b4.in_c = 8'h56; b4.in_opx = 2'd2; b4.in_opy = 2'd2;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (b4.out_valid !== 1'b1) begin bad++; $display("FAIL bubble_head_valid: got %b want 1", b4.out_valid); end
    total++; if (b4.out_x !== 8'h26) begin bad++; $display("FAIL bubble_head_x: got %h want 26", b4.out_x); end
    @(posedge clk); #1;
    b4.in_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (!b4.in_ready) break;
      n++;
      @(posedge clk); #1;
      b4.in_a = 8'($urandom);
    end
    total++; if (n !== 3) begin bad++; $display("FAIL bubble_accepts: got %0d want 3", n); end
    @(posedge clk); #1;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL bubble_drain: got %b want 0", b4.out_valid); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    b2.out_ready = 1'b0; b2.in_valid = 1'b1; rand_in2();
    @(posedge clk); #1;
    rand_in2();
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_valid: got %b want 0", b2.out_valid); end
    total++; if (b2.out_x !== 8'h00) begin bad++; $display("FAIL midrst_async_x: got %h want 00", b2.out_x); end
    @(posedge clk); #1;
    rst = 1'b0; b2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (b2.out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_ghost: got %0d want 0", seen); end
    total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", b2.in_ready); end
  endtask

  task automatic test_random();
    logic [15:0] q [$];
    logic [15:0] e;
    logic        pend, stall;
    logic [15:0] last;
    int          outs;
    q.delete(); pend = 1'b0; stall = 1'b0; last = '0; outs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (!pend) begin
        b2.in_valid = 1'($urandom_range(0, 1));
        rand_in2();
      end
      b2.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      total++; if (b2.in_ready !== ((q.size() < 2) || b2.out_ready)) begin
        bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, b2.in_ready, ((q.size() < 2) || b2.out_ready));
      end
      if (stall) begin
        total++; if (b2.out_valid !== 1'b1 || {b2.out_x, b2.out_y} !== last) begin
          bad++; $display("FAIL rand_hold[%0d]: got %b/%h want 1/%h", cyc, b2.out_valid, {b2.out_x, b2.out_y}, last);
        end
      end
      stall = b2.out_valid && !b2.out_ready;
      last  = {b2.out_x, b2.out_y};
      if (b2.out_valid && b2.out_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        total++; if ({b2.out_x, b2.out_y} !== e) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", outs, {b2.out_x, b2.out_y}, e); end
        outs++;
      end
      pend = b2.in_valid && !b2.in_ready;
      if (b2.in_valid && b2.in_ready)
        q.push_back({ref_op(b2.in_opx, b2.in_a, b2.in_b), ref_op(b2.in_opy, b2.in_b, b2.in_c)});
    end
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (b2.out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        total++; if ({b2.out_x, b2.out_y} !== e) begin bad++; $display("FAIL rand_drain_data: got %h want %h", {b2.out_x, b2.out_y}, e); end
      end
      @(posedge clk);
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rand_lost: got %0d left want 0", q.size()); end
  endtask

`ifdef ANDOR_PIPE_CNT_EN
  task automatic test_counter();
    int acc, emit;
    logic saw_busy;
    acc = 0; emit = 0; saw_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (cnt2 !== 16'd0) begin bad++; $display("FAIL cnt_start: got %0d want 0", cnt2); end
    @(posedge clk); #1;
    b2.in_valid = 1'b1;
    for (int cyc = 0; cyc < 66000 && emit < 65537; cyc++) begin
      @(negedge clk);
      if (busy2) saw_busy = 1'b1;
      if (b2.out_valid && b2.out_ready) emit++;
      if (b2.in_valid && b2.in_ready) acc++;
      @(posedge clk); #1;
      if (acc >= 65537) b2.in_valid = 1'b0;
    end
    total++; if (emit !== 65537) begin bad++; $display("FAIL cnt_transfers: got %0d want 65537", emit); end
    @(negedge clk);
    total++; if (cnt2 !== 16'd1) begin bad++; $display("FAIL cnt_wrap: got %0d want 1", cnt2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL cnt_busy_idle: got %b want 0", busy2); end
    total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL cnt_busy_active: got %b want 1", saw_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_ops();
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    test_random();
`ifdef ANDOR_PIPE_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
